// File: rtl/exp7_pkg.sv
// Shared definitions for the exp7 memory-sequence game: state codes, debug code for
// illegal states and small elaboration-time sizing helpers.
package exp7_pkg;

    localparam logic [3:0] ST_INICIAL        = 4'h0;
    localparam logic [3:0] ST_PREPARACAO     = 4'h1;
    localparam logic [3:0] ST_INICIA_RODADA  = 4'h2;
    localparam logic [3:0] ST_MOSTRA         = 4'h3;
    localparam logic [3:0] ST_APAGA          = 4'h4;
    localparam logic [3:0] ST_PROXIMO_MOSTRA = 4'h5;
    localparam logic [3:0] ST_PREPARA_JOGADA = 4'h6;
    localparam logic [3:0] ST_ESPERA         = 4'h7;
    localparam logic [3:0] ST_REGISTRA       = 4'h8;
    localparam logic [3:0] ST_COMPARACAO     = 4'h9;
    localparam logic [3:0] ST_PROXIMO        = 4'hA;
    localparam logic [3:0] ST_PROXIMA_RODADA = 4'hB;
    localparam logic [3:0] ST_FIM_A          = 4'hC;
    localparam logic [3:0] ST_FIM_T          = 4'hD;
    localparam logic [3:0] ST_FIM_E          = 4'hE;
    localparam logic [3:0] DB_INVALIDO       = 4'hF;

    typedef enum logic [3:0] {
        INICIAL        = ST_INICIAL,
        PREPARACAO     = ST_PREPARACAO,
        INICIA_RODADA  = ST_INICIA_RODADA,
        MOSTRA         = ST_MOSTRA,
        APAGA          = ST_APAGA,
        PROXIMO_MOSTRA = ST_PROXIMO_MOSTRA,
        PREPARA_JOGADA = ST_PREPARA_JOGADA,
        ESPERA         = ST_ESPERA,
        REGISTRA       = ST_REGISTRA,
        COMPARACAO     = ST_COMPARACAO,
        PROXIMO        = ST_PROXIMO,
        PROXIMA_RODADA = ST_PROXIMA_RODADA,
        FIM_A          = ST_FIM_A,
        FIM_T          = ST_FIM_T,
        FIM_E          = ST_FIM_E
    } estado_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int largura(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exp7_unidade_controle_if.sv
// Signals between the game controller (master) and the game datapath (slave).
interface exp7_unidade_controle_if;

    // iniciar, igual, enderecoIgualLimite and fimL are levels sampled every edge;
    // jogada is a one-cycle pulse. Every controller output is a Moore decode of the
    // current state and is valid for the whole cycle; no handshake acknowledges it.
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       enderecoIgualLimite;
    logic       fimL;
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       ativa_leds;
    logic       acertou;
    logic       errou;
    logic       pronto;
    logic       db_timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, igual, enderecoIgualLimite, fimL,
        output zeraE, contaE, zeraL, contaL, zeraR, registraR, ativa_leds,
               acertou, errou, pronto, db_timeout, db_estado
    );

    modport slave (
        output iniciar, jogada, igual, enderecoIgualLimite, fimL,
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR, ativa_leds,
               acertou, errou, pronto, db_timeout, db_estado
    );

endinterface

// File: rtl/exp7_timer.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count flag
// that compares against a run-time limit.
module exp7_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_zera,
    input  logic             i_conta,
    input  logic [WIDTH-1:0] i_limite,
    output logic             o_fim
);

    logic [WIDTH-1:0] r_valor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valor <= '0;
        end else if (i_zera) begin
            r_valor <= '0;
        end else if (i_conta && (r_valor != {WIDTH{1'b1}})) begin
            r_valor <= r_valor + WIDTH'(1);
        end
    end

    assign o_fim = (r_valor == i_limite);

endmodule

// File: rtl/exp7_unidade_controle.sv
// Moore controller for the memory-sequence game: playback, move collection, result.
// Optional build macro TIMEOUT_EN adds the move-timeout counter and the fim_T ending.
module exp7_unidade_controle
    import exp7_pkg::*;
#(
    parameter int SHOW_CYCLES    = 1000,
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                     clock,
    input  logic                     reset,
    exp7_unidade_controle_if.master  bus
);

    localparam int               DISP_W   = largura(max_int(SHOW_CYCLES, GAP_CYCLES));
    localparam logic [DISP_W-1:0] SHOW_FIM = DISP_W'(SHOW_CYCLES - 1);
    localparam logic [DISP_W-1:0] GAP_FIM  = DISP_W'(GAP_CYCLES - 1);

    estado_t           r_estado;
    estado_t           w_proximo;
    logic              w_em_display;
    logic              w_zera_disp;
    logic              w_fim_disp;
    logic [DISP_W-1:0] w_limite_disp;
    logic              w_timeout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // One display timer serves mostra and apaga; it restarts on every state change.
    assign w_em_display  = (r_estado == MOSTRA) || (r_estado == APAGA);
    assign w_zera_disp   = !w_em_display || (w_proximo != r_estado);
    assign w_limite_disp = (r_estado == MOSTRA) ? SHOW_FIM : GAP_FIM;

    exp7_timer #(
        .WIDTH (DISP_W)
    ) u_timer_display (
        .clock    (clock),
        .reset    (reset),
        .i_zera   (w_zera_disp),
        .i_conta  (w_em_display),
        .i_limite (w_limite_disp),
        .o_fim    (w_fim_disp)
    );

`ifdef TIMEOUT_EN
    localparam int             TO_W   = largura(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_FIM = TO_W'(TIMEOUT_CYCLES - 1);

    logic w_em_espera;
    logic w_zera_to;
    logic w_fim_to;

    // Leaving espera (e.g. through proximo) clears the window for the next move.
    assign w_em_espera = (r_estado == ESPERA);
    assign w_zera_to   = !w_em_espera || (w_proximo != r_estado);
    assign w_timeout   = w_em_espera && w_fim_to;

    exp7_timer #(
        .WIDTH (TO_W)
    ) u_timer_timeout (
        .clock    (clock),
        .reset    (reset),
        .i_zera   (w_zera_to),
        .i_conta  (w_em_espera),
        .i_limite (TO_FIM),
        .o_fim    (w_fim_to)
    );
`else
    // TIMEOUT_CYCLES has no effect in this build; espera waits for jogada forever.
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            INICIAL:        if (bus.iniciar) w_proximo = PREPARACAO;
            PREPARACAO:     w_proximo = INICIA_RODADA;
            INICIA_RODADA:  w_proximo = MOSTRA;
            MOSTRA:         if (w_fim_disp) w_proximo = APAGA;
            APAGA: begin
                if (w_fim_disp) begin
                    w_proximo = bus.enderecoIgualLimite ? PREPARA_JOGADA : PROXIMO_MOSTRA;
                end
            end
            PROXIMO_MOSTRA: w_proximo = MOSTRA;
            PREPARA_JOGADA: w_proximo = ESPERA;
            ESPERA: begin
                if (w_timeout)       w_proximo = FIM_T;
                else if (bus.jogada) w_proximo = REGISTRA;
            end
            REGISTRA:       w_proximo = COMPARACAO;
            COMPARACAO: begin
                if (!bus.igual)                    w_proximo = FIM_E;
                else if (!bus.enderecoIgualLimite) w_proximo = PROXIMO;
                else if (bus.fimL)                 w_proximo = FIM_A;
                else                               w_proximo = PROXIMA_RODADA;
            end
            PROXIMO:        w_proximo = ESPERA;
            PROXIMA_RODADA: w_proximo = INICIA_RODADA;
`ifdef TIMEOUT_EN
            FIM_A, FIM_E, FIM_T: if (bus.iniciar) w_proximo = PREPARACAO;
`else
            FIM_A, FIM_E:        if (bus.iniciar) w_proximo = PREPARACAO;
`endif
            default:        w_proximo = INICIAL;
        endcase
    end

    always_comb begin
        bus.zeraE      = 1'b0;
        bus.contaE     = 1'b0;
        bus.zeraL      = 1'b0;
        bus.contaL     = 1'b0;
        bus.zeraR      = 1'b0;
        bus.registraR  = 1'b0;
        bus.ativa_leds = 1'b0;
        bus.acertou    = 1'b0;
        bus.errou      = 1'b0;
        bus.pronto     = 1'b0;
        bus.db_timeout = 1'b0;
        bus.db_estado  = r_estado;
        case (r_estado)
            INICIAL, PREPARACAO: begin
                bus.zeraE = 1'b1;
                bus.zeraL = 1'b1;
                bus.zeraR = 1'b1;
            end
            INICIA_RODADA:  bus.zeraE = 1'b1;
            MOSTRA:         bus.ativa_leds = 1'b1;
            PROXIMO_MOSTRA: bus.contaE = 1'b1;
            PREPARA_JOGADA: begin
                bus.zeraE = 1'b1;
                bus.zeraR = 1'b1;
            end
            REGISTRA:       bus.registraR = 1'b1;
            PROXIMO:        bus.contaE = 1'b1;
            PROXIMA_RODADA: bus.contaL = 1'b1;
            APAGA, ESPERA, COMPARACAO: ;
            FIM_A: begin
                bus.acertou = 1'b1;
                bus.pronto  = 1'b1;
            end
            FIM_E: begin
                bus.errou  = 1'b1;
                bus.pronto = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_T: begin
                bus.errou      = 1'b1;
                bus.pronto     = 1'b1;
                bus.db_timeout = 1'b1;
            end
`endif
            default:        bus.db_estado = DB_INVALIDO;
        endcase
    end

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// Bench for exp7_unidade_controle: randomized games against a round/move level model
// of the memory-sequence game. Build with TIMEOUT_EN to exercise the timeout ending.
module tb_exp7_unidade_controle;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] mem [8];
    logic [1:0] exp_q [$];

    exp7_unidade_controle_if dut_if ();

    exp7_unidade_controle #(
        .SHOW_CYCLES    (SHOW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dut_if)
    );

    always #5 clock = ~clock;

    // Output table of each state, written straight from the state/output list.
    function automatic logic [10:0] tabela(input logic [3:0] s);
        logic [10:0] v;
        v     = '0;
        v[10] = s inside {4'h0, 4'h1, 4'h2, 4'h6};
        v[9]  = s inside {4'h0, 4'h1};
        v[8]  = s inside {4'h0, 4'h1, 4'h6};
        v[7]  = s inside {4'h5, 4'hA};
        v[6]  = (s == 4'hB);
        v[5]  = (s == 4'h8);
        v[4]  = (s == 4'h3);
        v[3]  = (s == 4'hC);
        v[2]  = s inside {4'hD, 4'hE};
        v[1]  = s inside {4'hC, 4'hD, 4'hE};
        v[0]  = (s == 4'hD);
        return v;
    endfunction

    function automatic logic [14:0] esperado(input logic [3:0] s);
        return {s, tabela(s)};
    endfunction

    function automatic logic [14:0] observa();
        return {dut_if.db_estado, dut_if.zeraE, dut_if.zeraL, dut_if.zeraR, dut_if.contaE,
                dut_if.contaL, dut_if.registraR, dut_if.ativa_leds, dut_if.acertou,
                dut_if.errou, dut_if.pronto, dut_if.db_timeout};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        dut_if.iniciar             = 1'b0;
        dut_if.jogada              = 1'b0;
        dut_if.igual               = 1'b0;
        dut_if.enderecoIgualLimite = 1'b0;
        dut_if.fimL                = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        dut_if.iniciar = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (observa() !== esperado(4'h0)) begin
            errors++;
            $display("FAIL reset_hold: got %h, expected %h", observa(), esperado(4'h0));
        end
        dut_if.iniciar = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (observa() !== esperado(4'h0)) begin
            errors++;
            $display("FAIL inicial_idle: got %h, expected %h", observa(), esperado(4'h0));
        end
    endtask

    // Pulse iniciar and follow 1 -> 2 -> 3; returns sampled in the first mostra cycle.
    task automatic start_game();
        dut_if.iniciar = 1'b1;
        tick();
        dut_if.iniciar = 1'b0;
        checks++;
        if (observa() !== esperado(4'h1)) begin
            errors++;
            $display("FAIL start_preparacao: got %h, expected %h", observa(), esperado(4'h1));
        end
        tick();
        checks++;
        if (observa() !== esperado(4'h2)) begin
            errors++;
            $display("FAIL start_inicia_rodada: got %h, expected %h", observa(), esperado(4'h2));
        end
        tick();
        checks++;
        if (observa() !== esperado(4'h3)) begin
            errors++;
            $display("FAIL start_mostra: got %h, expected %h", observa(), esperado(4'h3));
        end
    endtask

    // Playback of n moves: per move SHOW lit cycles, GAP dark cycles, and one dark
    // contaE cycle before every move except the last. Random jogada must be ignored.
    task automatic playback(input int n);
        logic [1:0] e;
        int addr;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            repeat (SHOW) exp_q.push_back(2'b10);
            repeat (GAP) exp_q.push_back(2'b00);
            if (k < n - 1) exp_q.push_back(2'b01);
        end
        addr = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({dut_if.ativa_leds, dut_if.contaE} !== e) begin
                errors++;
                $display("FAIL playback_n%0d: got leds/contaE=%b, expected %b", n,
                         {dut_if.ativa_leds, dut_if.contaE}, e);
            end
            if (dut_if.contaE === 1'b1) addr++;
            dut_if.enderecoIgualLimite = (addr == n - 1);
            dut_if.jogada = 1'($urandom_range(0, 1));
            tick();
        end
        dut_if.jogada = 1'b0;
        checks++;
        if (observa() !== esperado(4'h6)) begin
            errors++;
            $display("FAIL prepara_jogada: got %h, expected %h", observa(), esperado(4'h6));
        end
        tick();
        checks++;
        if (observa() !== esperado(4'h7)) begin
            errors++;
            $display("FAIL espera_entrada: got %h, expected %h", observa(), esperado(4'h7));
        end
    endtask

    // Player answers for a round of n moves; errada marks the wrong move (-1 none),
    // atraso fixes the idle cycles before each move (-1 random).
    task automatic play_moves(input int n, input bit ultima, input int errada, input int atraso);
        for (int m = 0; m < n; m++) begin
            int d;
            logic [1:0] lance;
            bit acerto;
            d = (atraso < 0) ? $urandom_range(0, 3) : atraso;
            for (int i = 0; i < d; i++) begin
                tick();
                checks++;
                if (observa() !== esperado(4'h7)) begin
                    errors++;
                    $display("FAIL espera_ociosa: got %h, expected %h", observa(), esperado(4'h7));
                end
            end
            lance = (m == errada) ? mem[m] + 2'($urandom_range(1, 3)) : mem[m];
            acerto = (lance == mem[m]);
            dut_if.igual = acerto;
            dut_if.enderecoIgualLimite = (m == n - 1);
            dut_if.fimL = ultima;
            dut_if.jogada = 1'b1;
            tick();
            dut_if.jogada = 1'b0;
            checks++;
            if (observa() !== esperado(4'h8)) begin
                errors++;
                $display("FAIL registra: got %h, expected %h", observa(), esperado(4'h8));
            end
            tick();
            checks++;
            if (observa() !== esperado(4'h9)) begin
                errors++;
                $display("FAIL comparacao: got %h, expected %h", observa(), esperado(4'h9));
            end
            tick();
            if (!acerto) begin
                checks++;
                if (observa() !== esperado(4'hE)) begin
                    errors++;
                    $display("FAIL fim_erro: got %h, expected %h", observa(), esperado(4'hE));
                end
                return;
            end
            if (m < n - 1) begin
                checks++;
                if (observa() !== esperado(4'hA)) begin
                    errors++;
                    $display("FAIL proximo: got %h, expected %h", observa(), esperado(4'hA));
                end
                tick();
                checks++;
                if (observa() !== esperado(4'h7)) begin
                    errors++;
                    $display("FAIL proximo_espera: got %h, expected %h", observa(), esperado(4'h7));
                end
            end else if (ultima) begin
                checks++;
                if (observa() !== esperado(4'hC)) begin
                    errors++;
                    $display("FAIL fim_acerto: got %h, expected %h", observa(), esperado(4'hC));
                end
            end else begin
                checks++;
                if (observa() !== esperado(4'hB)) begin
                    errors++;
                    $display("FAIL proxima_rodada: got %h, expected %h", observa(), esperado(4'hB));
                end
                tick();
                checks++;
                if (observa() !== esperado(4'h2)) begin
                    errors++;
                    $display("FAIL nova_rodada: got %h, expected %h", observa(), esperado(4'h2));
                end
                tick();
                checks++;
                if (observa() !== esperado(4'h3)) begin
                    errors++;
                    $display("FAIL nova_mostra: got %h, expected %h", observa(), esperado(4'h3));
                end
            end
        end
    endtask

    task automatic test_full_game();
        int nr;
        nr = $urandom_range(2, 4);
        for (int i = 0; i < 8; i++) mem[i] = 2'($urandom_range(0, 3));
        start_game();
        for (int r = 1; r <= nr; r++) begin
            playback(r);
            play_moves(r, (r == nr), -1, -1);
        end
        tick();
        checks++;
        if (observa() !== esperado(4'hC)) begin
            errors++;
            $display("FAIL fim_acerto_mantem: got %h, expected %h", observa(), esperado(4'hC));
        end
    endtask

    task automatic test_wrong_move();
        int nr;
        int wr;
        int wm;
        nr = $urandom_range(2, 4);
        wr = $urandom_range(1, nr);
        wm = $urandom_range(0, wr - 1);
        for (int i = 0; i < 8; i++) mem[i] = 2'($urandom_range(0, 3));
        start_game();
        for (int r = 1; r <= wr; r++) begin
            playback(r);
            play_moves(r, (r == nr), (r == wr) ? wm : -1, -1);
        end
        tick();
        checks++;
        if (observa() !== esperado(4'hE)) begin
            errors++;
            $display("FAIL fim_erro_mantem: got %h, expected %h", observa(), esperado(4'hE));
        end
    endtask

`ifdef TIMEOUT_EN
    task automatic test_timeout();
        int cnt;
        start_game();
        playback(1);
        cnt = 1;
        for (int i = 0; i < 3 * TMO; i++) begin
            tick();
            if (dut_if.db_estado !== 4'h7) break;
            cnt++;
        end
        checks++;
        if (cnt !== TMO) begin
            errors++;
            $display("FAIL timeout_janela: got %0d cycles in espera, expected %0d", cnt, TMO);
        end
        checks++;
        if (observa() !== esperado(4'hD)) begin
            errors++;
            $display("FAIL fim_timeout: got %h, expected %h", observa(), esperado(4'hD));
        end
        start_game();
        playback(1);
        repeat (TMO - 1) tick();
        checks++;
        if (observa() !== esperado(4'h7)) begin
            errors++;
            $display("FAIL timeout_ultimo_ciclo: got %h, expected %h", observa(), esperado(4'h7));
        end
        dut_if.igual = 1'b1;
        dut_if.enderecoIgualLimite = 1'b1;
        dut_if.fimL = 1'b1;
        dut_if.jogada = 1'b1;
        tick();
        dut_if.jogada = 1'b0;
        checks++;
        if (observa() !== esperado(4'hD)) begin
            errors++;
            $display("FAIL timeout_vence_jogada: got %h, expected %h", observa(), esperado(4'hD));
        end
        start_game();
        playback(1);
        play_moves(1, 1'b0, -1, TMO - 2);
        playback(2);
        play_moves(2, 1'b1, -1, TMO - 2);
    endtask
`else
    task automatic test_no_timeout();
        start_game();
        playback(1);
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (observa() !== esperado(4'h7)) begin
                errors++;
                $display("FAIL espera_sem_timeout: cycle %0d got %h, expected %h", i, observa(),
                         esperado(4'h7));
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        reset = 1'b0;
        #1;
        checks++;
        if (observa() !== esperado(4'h0)) begin
            errors++;
            $display("FAIL reset_assincrono: got %h, expected %h", observa(), esperado(4'h0));
        end
        #1;
        reset = 1'b1;
        tick();
        start_game();
        tick();
        checks++;
        if (observa() !== esperado(4'h3)) begin
            errors++;
            $display("FAIL mostra_segundo_ciclo: got %h, expected %h", observa(), esperado(4'h3));
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (observa() !== esperado(4'h0)) begin
            errors++;
            $display("FAIL reset_em_mostra: got %h, expected %h", observa(), esperado(4'h0));
        end
        #1;
        reset = 1'b1;
        tick();
        checks++;
        if (observa() !== esperado(4'h0)) begin
            errors++;
            $display("FAIL pos_reset: got %h, expected %h", observa(), esperado(4'h0));
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_full_game();
        test_wrong_move();
`ifdef TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp7_unidade_controle.md
# exp7_unidade_controle

Moore controller for the memory-sequence game ("Genius" flavour). Each round it plays back the stored sequence up to the current limit on the LEDs, then collects and compares the player's moves against that sequence. It sequences the game datapath: address counter, limit counter, play register, comparator and memory-driven LEDs. It owns the LED display timer and the move-timeout counter.

## Interface
- SHOW_CYCLES, 1000: cycles each stored move stays lit during playback.
- GAP_CYCLES, 250: dark cycles after each displayed move.
- TIMEOUT_CYCLES, 5000: idle cycles allowed in `espera` before timeout (only with `TIMEOUT_EN`).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- iniciar  in  1  start / restart request, level-sampled.
- jogada  in  1  one-cycle pulse per player move, from the datapath edge detector.
- igual  in  1  comparator: registered move equals memory at current address.
- enderecoIgualLimite  in  1  address counter equals limit counter.
- fimL  in  1  limit counter at last round.
- zeraE, contaE  out  1  clear / increment the address counter.
- zeraL, contaL  out  1  clear / increment the limit counter.
- zeraR, registraR  out  1  clear / load the play register.
- ativa_leds  out  1  LEDs show memory data at the current address.
- acertou, errou, pronto  out  1  game result flags.
- db_timeout  out  1  game ended by timeout.
- db_estado  out  4  current state code.

## Operation
- States (code): inicial 0, preparacao 1, inicia_rodada 2, mostra 3, apaga 4, proximo_mostra 5, prepara_jogada 6, espera 7, registra 8, comparacao 9, proximo A, proxima_rodada B, fim_A C, fim_T D, fim_E E. Illegal codes go to inicial; db_estado shows F for them.
- inicial: if iniciar, go to preparacao.
- preparacao: go to inicia_rodada.
- inicia_rodada: go to mostra.
- mostra: on timer = SHOW_CYCLES-1, go to apaga.
- apaga: on timer = GAP_CYCLES-1, go to prepara_jogada if enderecoIgualLimite, else proximo_mostra.
- proximo_mostra: go to mostra.
- prepara_jogada: go to espera.
- espera: on timeout go to fim_T; else on jogada go to registra; otherwise stay.
- registra: go to comparacao.
- comparacao:
  - !igual: fim_E.
  - !enderecoIgualLimite: proximo.
  - fimL: fim_A.
  - otherwise: proxima_rodada.
- proximo: go to espera.
- proxima_rodada: go to inicia_rodada.
- fim_A, fim_E, fim_T: if iniciar, go to preparacao (restart without reset).
- Outputs are a function of state only:
  - zeraE: in 0, 1, 2, 6.
  - zeraL: in 0, 1.
  - zeraR: in 0, 1, 6.
  - contaE: in 5 and A.
  - contaL: in B.
  - registraR: in 8.
  - ativa_leds: in 3.
  - acertou: in C.
  - errou: in D and E.
  - pronto: in C, D, E.
  - db_timeout: in D.
- Display timer: one counter shared by mostra and apaga. Width is clog2 of max(SHOW_CYCLES, GAP_CYCLES). It is zero on the first cycle of each state, increments while in state, and never wraps.
- Timeout counter: counts only in espera and is zero in every other state. Passing through proximo restarts the window for each move.

## Timing
- During reset: state = inicial. zeraE = zeraL = zeraR = 1, all other outputs 0, db_estado = 0, both counters 0.
- Reset mid-operation: immediate, asynchronous return to inicial. Outputs take inicial values without waiting for a clock edge.
- Latency:
  - iniciar to first ativa_leds: 3 edges (1, 2, 3).
  - jogada to comparacao outcome: 2 edges.
- ativa_leds high exactly SHOW_CYCLES cycles per move, followed by exactly GAP_CYCLES low cycles.
- Each contaE, contaL and registraR pulse is exactly 1 cycle.
- Timeout fires when the count is TIMEOUT_CYCLES-1 in espera.
- If jogada and timeout occur in the same cycle, timeout wins.
- jogada outside espera is ignored.

## Configuration
- `TIMEOUT_EN` defined: the timeout counter is built, fim_T is reachable, and db_timeout behaves as specified.
- `TIMEOUT_EN` undefined:
  - timeout counter removed; TIMEOUT_CYCLES unused.
  - espera waits indefinitely for jogada.
  - db_timeout tied to 0; fim_T unreachable (treated as illegal and routed to inicial).

## Structure
- Shared package `exp7_pkg` holds the 4-bit state-code localparams and the db_estado code for illegal states (F). The datapath and 7-segment debug decoder import it.
- One sub-module: `exp7_timer`, a parameterised up-counter with synchronous clear, enable and terminal-count flag. Instance 1 is the display timer; instance 2 is the timeout counter, present only under `TIMEOUT_EN`.

## Test plan
Bench parameters: SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=10.
- Reset low, release, pulse iniciar with enderecoIgualLimite=1: db_estado 0→1→2→3, ativa_leds high 4 cycles, 2 dark cycles, then db_estado 6 then 7.
- Round 2 playback with enderecoIgualLimite=0 at the first apaga: one contaE pulse, ativa_leds shows two 4-cycle bursts, then state 6.
- Full correct game, with igual=1 on every move and fimL=1 on the last round: reach fim_A, acertou=pronto=1, errou=0, db_estado=C. Pulsing iniciar then returns to state 1.
- Wrong move (igual=0 in comparacao): fim_E, errou=pronto=1, db_estado=E.
- No jogada for 10 cycles in espera: fim_T, db_timeout=errou=1, db_estado=D. Separately, jogada asserted in the 10th cycle still goes to D.
- Drive reset low during mostra: ativa_leds=0 and db_estado=0 before the next clock edge. Build without `TIMEOUT_EN`, idle 100 cycles in espera: stays in 7, db_timeout=0.
